// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   - FSM state encoding (legacy two-bit constants)
//   - default operand width
//   - helper to size the bit counter
package serial_subtractor_pkg;

  // Default operand/result width in bits (legal range 1..32).
  localparam int unsigned DefaultWidth = 8;

  // FSM state encoding.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // Counter width for a given operand width.
  // The extra bit keeps WIDTH=1 at a legal one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/half_subtractor.sv
// Combinational half subtractor: computes A - B for a single bit.
// Ports:
//   A      - minuend bit
//   B      - subtrahend bit
//   Diff   - difference bit, A ^ B
//   Borrow - borrow out, set when A=0 and B=1
module half_subtractor (
  input  logic A,
  input  logic B,
  output logic Diff,
  output logic Borrow
);

  assign Diff   = A ^ B;
  assign Borrow = ~A & B;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = (A - B) mod 2^WIDTH, LSB first, one bit per clock.
// A start/busy/done handshake frames each operation; a new start is accepted in IDLE or
// in the DONE cycle, so back-to-back operations run at one result per WIDTH+1 cycles.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset, has priority over start
//   start  - request, sampled only while busy=0
//   A, B   - minuend / subtrahend, captured on the accept edge
//   busy   - high while operand bits are being processed
//   done   - one-cycle pulse while Diff/Borrow hold a fresh result
//   Diff   - registered result, holds until the next operation completes
//   Borrow - final borrow out, 1 iff A < B (unsigned)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;

  // Per-bit full subtractor: two half subtractors plus an OR on their borrows.
  logic hs0_diff, hs0_borrow;
  logic bit_diff, hs1_borrow;
  logic bit_bout;

  half_subtractor u_hs0 (
    .A      (a_q[0]),
    .B      (b_q[0]),
    .Diff   (hs0_diff),
    .Borrow (hs0_borrow)
  );

  half_subtractor u_hs1 (
    .A      (hs0_diff),
    .B      (bin_q),
    .Diff   (bit_diff),
    .Borrow (hs1_borrow)
  );

  assign bit_bout = hs0_borrow | hs1_borrow;

  // Result register with the new bit entering at the MSB end; after WIDTH shifts the
  // first-computed (LSB) bit has arrived at position 0.
  logic [WIDTH-1:0] res_shifted;

  generate
    if (WIDTH == 1) begin : g_single
      assign res_shifted = bit_diff;
    end else begin : g_multi
      assign res_shifted = {bit_diff, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          res_d   = '0;
          cnt_d   = '0;
          bin_d   = 1'b0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end

      StShift: begin
        // Operands shift right so the active bit is always at index 0; this is
        // equivalent to selecting bit[count] without a variable-width index.
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shifted;
        bin_d = bit_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          // Publish the result on the edge entering DONE so it is valid with done.
          diff_d   = res_shifted;
          borrow_d = bit_bout;
          state_d  = StDone;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);
  assign Diff   = diff_q;
  assign Borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Latency is counted in samples taken 1 time unit after each rising edge, starting at
// the accept edge (k=0): busy is expected for k=0..W-1 and done exactly at k=W.
module tb_serial_subtractor;

  localparam int unsigned W8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start8, busy8, done8, borrow8;
  logic [W8-1:0] a8, b8, diff8;
  logic          start1, busy1, done1, borrow1;
  logic [0:0]    a1, b1, diff1;

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(W8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start8),
    .A      (a8),
    .B      (b8),
    .busy   (busy8),
    .done   (done8),
    .Diff   (diff8),
    .Borrow (borrow8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .A      (a1),
    .B      (b1),
    .busy   (busy1),
    .done   (done1),
    .Diff   (diff1),
    .Borrow (borrow1)
  );

  // Reference: plain modular arithmetic and unsigned comparison.
  function automatic logic [W8:0] ref8(input int unsigned a, input int unsigned b);
    int unsigned d;
    d = a - b;
    return {a < b, d[W8-1:0]};
  endfunction

  // Launch one WIDTH=8 operation from IDLE/DONE and wait (bounded) for done.
  task automatic run8(input logic [W8-1:0] a, input logic [W8-1:0] b,
                      output logic [W8-1:0] d, output logic bo,
                      output int lat, output int nbusy);
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    lat    = -1;
    nbusy  = 0;
    d      = '0;
    bo     = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done8) begin
        lat = k;
        d   = diff8;
        bo  = borrow8;
        break;
      end
      if (busy8) nbusy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run1(input logic a, input logic b, output logic d, output logic bo,
                      output int lat);
    start1 = 1'b1;
    a1     = a;
    b1     = b;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat    = -1;
    d      = 1'b0;
    bo     = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done1) begin
        lat = k;
        d   = diff1[0];
        bo  = borrow1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start8 = 1'b1;  // reset must win over start
    start1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_w8: got busy=%b done=%b diff=%0d borrow=%b, expected all 0",
               busy8, done8, diff8, borrow8);
    end
    n_tests++;
    if ({busy1, done1, diff1, borrow1} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_w1: got busy=%b done=%b diff=%0d borrow=%b, expected all 0",
               busy1, done1, diff1, borrow1);
    end
    rst    = 1'b0;
    start8 = 1'b0;
    start1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W8-1:0] ta [4] = '{8'd100, 8'd5, 8'd0, 8'd255};
    logic [W8-1:0] tb [4] = '{8'd37, 8'd10, 8'd255, 8'd255};
    logic [W8-1:0] d;
    logic          bo;
    logic [W8:0]   exp;
    int            lat, nbusy;
    for (int i = 0; i < 4; i++) begin
      exp = ref8(ta[i], tb[i]);
      run8(ta[i], tb[i], d, bo, lat, nbusy);
      n_tests++;
      if ({bo, d} !== exp) begin
        n_fail++;
        $display("FAIL directed_result %0d-%0d: got diff=%0d borrow=%b, expected diff=%0d borrow=%b",
                 ta[i], tb[i], d, bo, exp[W8-1:0], exp[W8]);
      end
      n_tests++;
      if (lat != W8 || nbusy != W8) begin
        n_fail++;
        $display("FAIL directed_timing %0d-%0d: got done_at=%0d busy_cycles=%0d, expected %0d/%0d",
                 ta[i], tb[i], lat, nbusy, W8, W8);
      end
      @(posedge clk); #1;
      n_tests++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_done_pulse: got done=%b busy=%b after DONE, expected 0/0",
                 done8, busy8);
      end
    end
  endtask

  task automatic test_width1();
    logic d, bo, ea, eb;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      ea = (i >= 2);
      eb = (i % 2 == 1);
      run1(ea, eb, d, bo, lat);
      n_tests++;
      // 1-bit subtraction: diff is XOR, borrow only for 0-1.
      if (d !== (ea ^ eb) || bo !== (!ea && eb) || lat != 1) begin
        n_fail++;
        $display("FAIL width1 %b-%b: got diff=%b borrow=%b done_at=%0d, expected %b/%b/1",
                 ea, eb, d, bo, lat, ea ^ eb, (!ea && eb));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [W8-1:0] a, b, d;
    logic          bo;
    logic [W8:0]   exp;
    int            lat, nbusy;
    for (int i = 0; i < 24; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      exp = ref8(a, b);
      run8(a, b, d, bo, lat, nbusy);
      n_tests++;
      if ({bo, d} !== exp || lat != W8) begin
        n_fail++;
        $display("FAIL random %0d-%0d: got diff=%0d borrow=%b done_at=%0d, expected %0d/%b/%0d",
                 a, b, d, bo, lat, exp[W8-1:0], exp[W8], W8);
      end
      // Alternate between back-to-back and idle gaps.
      if (i % 2 == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W8-1:0] a, b, prev;
    logic [W8:0]   exp;
    logic          held;
    int            lat;
    a    = 8'($urandom_range(2, 255));
    b    = 8'($urandom);
    exp  = ref8(a, b);
    prev = diff8;
    held = 1'b1;
    lat  = -1;
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done8) begin
        lat = k;
        break;
      end
      if (diff8 !== prev) held = 1'b0;
      start8 = (k == 2);
      a8     = 8'd1;
      b8     = 8'd1;
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    n_tests++;
    if ({borrow8, diff8} !== exp || lat != W8) begin
      n_fail++;
      $display("FAIL ignore_start: got diff=%0d borrow=%b done_at=%0d, expected %0d/%b/%0d",
               diff8, borrow8, lat, exp[W8-1:0], exp[W8], W8);
    end
    n_tests++;
    if (!held) begin
      n_fail++;
      $display("FAIL output_hold: Diff changed during SHIFT, expected it to stay %0d", prev);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W8:0] exp1, exp2;
    logic        held;
    int          lat1, lat2;
    exp1   = ref8(200, 100);
    exp2   = ref8(10, 20);
    lat1   = -1;
    lat2   = -1;
    held   = 1'b1;
    start8 = 1'b1;
    a8     = 8'd200;
    b8     = 8'd100;
    @(posedge clk); #1;
    for (int k = 0; k < 40; k++) begin
      if (done8) begin
        lat1 = k;
        break;
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if ({borrow8, diff8} !== exp1 || lat1 != W8) begin
      n_fail++;
      $display("FAIL b2b_first: got diff=%0d borrow=%b done_at=%0d, expected %0d/%b/%0d",
               diff8, borrow8, lat1, exp1[W8-1:0], exp1[W8], W8);
    end
    // start still high: new operands presented in the DONE cycle.
    a8 = 8'd10;
    b8 = 8'd20;
    @(posedge clk); #1;
    for (int k = 0; k < 40; k++) begin
      if (done8) begin
        lat2 = k;
        break;
      end
      if (diff8 !== exp1[W8-1:0]) held = 1'b0;
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    n_tests++;
    // Second done W+1 samples after the first one.
    if ({borrow8, diff8} !== exp2 || lat2 != W8) begin
      n_fail++;
      $display("FAIL b2b_second: got diff=%0d borrow=%b done_at=%0d, expected %0d/%b/%0d",
               diff8, borrow8, lat2, exp2[W8-1:0], exp2[W8], W8);
    end
    n_tests++;
    if (!held) begin
      n_fail++;
      $display("FAIL b2b_hold: Diff changed during second SHIFT, expected %0d", exp1[W8-1:0]);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got done=%b busy=%b, expected 0/0", done8, busy8);
    end
  endtask

  task automatic test_reset_mid();
    logic [W8-1:0] a, b, d;
    logic          bo, seen;
    logic [W8:0]   exp;
    int            lat, nbusy;
    // Leave a nonzero result in the output registers first.
    run8(8'd77, 8'd30, d, bo, lat, nbusy);
    @(posedge clk); #1;
    start8 = 1'b1;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b diff=%0d borrow=%b, expected all 0",
               busy8, done8, diff8, borrow8);
    end
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done8 || busy8) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got activity (busy/done) after reset, expected none");
    end
    a   = 8'($urandom);
    b   = 8'($urandom);
    exp = ref8(a, b);
    run8(a, b, d, bo, lat, nbusy);
    n_tests++;
    if ({bo, d} !== exp || lat != W8) begin
      n_fail++;
      $display("FAIL reset_mid_fresh %0d-%0d: got diff=%0d borrow=%b done_at=%0d, expected %0d/%b/%0d",
               a, b, d, bo, lat, exp[W8-1:0], exp[W8], W8);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst    = 1'b1;
    start8 = 1'b0;
    start1 = 1'b0;
    a8     = '0;
    b8     = '0;
    a1     = '0;
    b1     = '0;
    test_reset();
    test_directed();
    test_width1();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
